// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared pipeline constants and writeback control record
package wb_stage_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic [2:0] funct3;
        logic [1:0] byte_offset;
    } wb_ctrl_t;

endpackage

// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - MEM-to-WB bus, register file ports and bypass/status outputs
interface wb_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = wb_stage_pkg::REG_ADDR_W
);
    logic              in_valid;
    logic              stall;
    logic              flush;
    logic              reg_write_in;
    logic [ADDR_W-1:0] rd_addr_in;
    logic [1:0]        wb_sel;
    logic [2:0]        load_funct3;
    logic [1:0]        byte_offset;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] read_port_addr1;
    logic [ADDR_W-1:0] read_port_addr2;
    logic [DATA_W-1:0] rf_read_data1;
    logic [DATA_W-1:0] rf_read_data2;
    logic [ADDR_W-1:0] write_port_addr;
    logic [DATA_W-1:0] write_data;
    logic              write_en;
    logic [DATA_W-1:0] byp_read_data1;
    logic [DATA_W-1:0] byp_read_data2;
    logic              wb_valid;
    logic [31:0]       instret;

    modport slave (
        input  in_valid, stall, flush, reg_write_in, rd_addr_in, wb_sel,
               load_funct3, byte_offset, alu_result, mem_rdata, pc_plus4,
               read_port_addr1, read_port_addr2, rf_read_data1, rf_read_data2,
        output write_port_addr, write_data, write_en,
               byp_read_data1, byp_read_data2, wb_valid, instret
    );

    modport master (
        output in_valid, stall, flush, reg_write_in, rd_addr_in, wb_sel,
               load_funct3, byte_offset, alu_result, mem_rdata, pc_plus4,
               read_port_addr1, read_port_addr2, rf_read_data1, rf_read_data2,
        input  write_port_addr, write_data, write_en,
               byp_read_data1, byp_read_data2, wb_valid, instret
    );

endinterface

// File: rtl/wb_stage_load_extend.sv
// rtl/wb_stage_load_extend.sv - picks the loaded byte/half lane and sign- or zero-extends it
module wb_stage_load_extend
    import wb_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        funct3_i,
    input  logic [1:0]        byte_offset_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] ext_data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Misaligned halves ignore byte_offset[0]; the lane is chosen by bit 1 alone.
    always_comb begin
        byte_lane = mem_rdata_i[{byte_offset_i, 3'b000} +: 8];
        half_lane = byte_offset_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (funct3_i)
            F3_LB:   ext_data_o = {{(DATA_W-8){byte_lane[7]}}, byte_lane};
            F3_LBU:  ext_data_o = {{(DATA_W-8){1'b0}}, byte_lane};
            F3_LH:   ext_data_o = {{(DATA_W-16){half_lane[15]}}, half_lane};
            F3_LHU:  ext_data_o = {{(DATA_W-16){1'b0}}, half_lane};
            F3_LW:   ext_data_o = mem_rdata_i;
            default: ext_data_o = mem_rdata_i;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB register, writeback select, register file write port, bypass and instret
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic       clk,
    input  logic       rst,
    wb_stage_if.slave  bus
);

    wb_ctrl_t          ctrl_q, ctrl_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] mem_q, mem_d;
    logic [DATA_W-1:0] pc4_q, pc4_d;
    logic [31:0]       instret_q, instret_d;

    logic [DATA_W-1:0] ext_data;
    logic [DATA_W-1:0] wb_data;
    logic              wr_en;

    always_comb begin
        ctrl_d = ctrl_q;
        rd_d   = rd_q;
        alu_d  = alu_q;
        mem_d  = mem_q;
        pc4_d  = pc4_q;
        if (bus.flush) begin
            ctrl_d = '0;
            rd_d   = '0;
            alu_d  = '0;
            mem_d  = '0;
            pc4_d  = '0;
        end else if (!bus.stall) begin
            ctrl_d.valid       = bus.in_valid;
            ctrl_d.reg_write   = bus.reg_write_in;
            ctrl_d.wb_sel      = bus.wb_sel;
            ctrl_d.funct3      = bus.load_funct3;
            ctrl_d.byte_offset = bus.byte_offset;
            rd_d               = bus.rd_addr_in;
            alu_d              = bus.alu_result;
            mem_d              = bus.mem_rdata;
            pc4_d              = bus.pc_plus4;
        end
    end

    // An entry retires when it leaves the stage: not held, or pushed out by a flush.
    always_comb begin
        instret_d = instret_q;
        if (ctrl_q.valid && (!bus.stall || bus.flush)) begin
            instret_d = instret_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q    <= '0;
            rd_q      <= '0;
            alu_q     <= '0;
            mem_q     <= '0;
            pc4_q     <= '0;
            instret_q <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            rd_q      <= rd_d;
            alu_q     <= alu_d;
            mem_q     <= mem_d;
            pc4_q     <= pc4_d;
            instret_q <= instret_d;
        end
    end

    wb_stage_load_extend #(
        .DATA_W (DATA_W)
    ) u_load_extend (
        .funct3_i      (ctrl_q.funct3),
        .byte_offset_i (ctrl_q.byte_offset),
        .mem_rdata_i   (mem_q),
        .ext_data_o    (ext_data)
    );

    always_comb begin
        case (ctrl_q.wb_sel)
            WB_SEL_MEM: wb_data = ext_data;
            WB_SEL_PC4: wb_data = pc4_q;
            WB_SEL_ALU: wb_data = alu_q;
            default:    wb_data = alu_q;
        endcase
    end

    assign wr_en = ctrl_q.valid & ctrl_q.reg_write & (rd_q != '0);

    assign bus.write_en        = wr_en;
    assign bus.write_port_addr = rd_q;
    assign bus.write_data      = wb_data;
    assign bus.wb_valid        = ctrl_q.valid;
    assign bus.instret         = instret_q;

    // wr_en already excludes x0, so address 0 always reads the raw register file.
    assign bus.byp_read_data1 = (wr_en && (bus.read_port_addr1 == rd_q)) ? wb_data : bus.rf_read_data1;
    assign bus.byp_read_data2 = (wr_en && (bus.read_port_addr2 == rd_q)) ? wb_data : bus.rf_read_data2;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed and randomized checks of wb_stage against a behavioural model
module tb_wb_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_stage_if bus ();

    wb_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    bit          m_init = 1'b0;
    bit          m_valid, m_rw, m_known;
    logic [4:0]  m_rd;
    logic [31:0] m_val;
    logic [31:0] m_instret;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_wb(input logic [1:0] sel, input logic [2:0] f3,
                                           input logic [1:0] off, input logic [31:0] alu,
                                           input logic [31:0] mem, input logic [31:0] pc4);
        logic [31:0] v;
        if (sel == 2'd2) return pc4;
        if (sel != 2'd1) return alu;
        case (f3)
            3'd0, 3'd4: begin
                v = (mem >> (8 * int'(off))) % 32'd256;
                if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
            end
            3'd1, 3'd5: begin
                v = (mem >> (16 * int'(off[1]))) % 32'd65536;
                if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = mem;
        endcase
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_init    = 1'b1;
            m_valid   = 1'b0;
            m_rw      = 1'b0;
            m_rd      = 5'd0;
            m_val     = 32'd0;
            m_known   = 1'b1;
            m_instret = 32'd0;
        end else if (m_init) begin
            if (m_valid && (!bus.stall || bus.flush)) m_instret = m_instret + 32'd1;
            if (bus.flush) begin
                m_valid = 1'b0;
                m_known = 1'b0;
            end else if (!bus.stall) begin
                m_valid = bus.in_valid;
                m_rw    = bus.reg_write_in;
                m_rd    = bus.rd_addr_in;
                m_val   = exp_wb(bus.wb_sel, bus.load_funct3, bus.byte_offset,
                                 bus.alu_result, bus.mem_rdata, bus.pc_plus4);
                m_known = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        logic exp_we;
        if (m_init) begin
            exp_we = m_valid && m_rw && (m_rd != 5'd0);
            chk("write_en", 32'(bus.write_en), 32'(exp_we));
            chk("wb_valid", 32'(bus.wb_valid), 32'(m_valid));
            chk("instret", bus.instret, m_instret);
            chk("byp1", bus.byp_read_data1,
                (exp_we && bus.read_port_addr1 == m_rd) ? m_val : bus.rf_read_data1);
            chk("byp2", bus.byp_read_data2,
                (exp_we && bus.read_port_addr2 == m_rd) ? m_val : bus.rf_read_data2);
            if (m_known) begin
                chk("write_port_addr", 32'(bus.write_port_addr), 32'(m_rd));
                chk("write_data", bus.write_data, m_val);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid        = 1'b0;
        bus.stall           = 1'b0;
        bus.flush           = 1'b0;
        bus.reg_write_in    = 1'b0;
        bus.rd_addr_in      = 5'd0;
        bus.wb_sel          = 2'd0;
        bus.load_funct3     = 3'd0;
        bus.byte_offset     = 2'd0;
        bus.alu_result      = 32'd0;
        bus.mem_rdata       = 32'd0;
        bus.pc_plus4        = 32'd0;
        bus.read_port_addr1 = 5'd0;
        bus.read_port_addr2 = 5'd0;
        bus.rf_read_data1   = 32'd0;
        bus.rf_read_data2   = 32'd0;
    endtask

    task automatic put(input logic [4:0] rd, input logic [1:0] sel, input logic [2:0] f3,
                       input logic [1:0] off, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [31:0] pc4);
        bus.in_valid     = 1'b1;
        bus.reg_write_in = 1'b1;
        bus.rd_addr_in   = rd;
        bus.wb_sel       = sel;
        bus.load_funct3  = f3;
        bus.byte_offset  = off;
        bus.alu_result   = alu;
        bus.mem_rdata    = mem;
        bus.pc_plus4     = pc4;
    endtask

    logic [2:0]  ld_f3  [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    logic [1:0]  ld_off [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0};
    logic [31:0] ld_exp [5] = '{32'hFFFFFFA5, 32'h000000F0, 32'hFFFF8077, 32'h0000F0A5, 32'h8077F0A5};

    initial begin
        rst = 1'b1;
        idle();
        cyc();
        cyc();
        chk("rst_we", 32'(bus.write_en), 32'd0);
        chk("rst_addr", 32'(bus.write_port_addr), 32'd0);
        chk("rst_data", bus.write_data, 32'd0);
        chk("rst_valid", 32'(bus.wb_valid), 32'd0);
        chk("rst_instret", bus.instret, 32'd0);
        rst = 1'b0;

        put(5'd1, 2'd0, 3'd0, 2'd0, 32'h0C70F26F, 32'd0, 32'd0);
        bus.read_port_addr1 = 5'd1;
        bus.rf_read_data1   = 32'd0;
        cyc();
        chk("wr_we", 32'(bus.write_en), 32'd1);
        chk("wr_addr", 32'(bus.write_port_addr), 32'd1);
        chk("wr_data", bus.write_data, 32'h0C70F26F);
        chk("wr_byp1", bus.byp_read_data1, 32'h0C70F26F);
        chk("wr_instret0", bus.instret, 32'd0);
        idle();
        cyc();
        chk("wr_instret1", bus.instret, 32'd1);

        put(5'd0, 2'd0, 3'd0, 2'd0, 32'hDEADBEEF, 32'd0, 32'd0);
        cyc();
        chk("x0_we", 32'(bus.write_en), 32'd0);
        chk("x0_byp2", bus.byp_read_data2, 32'd0);
        idle();
        cyc();
        chk("x0_instret", bus.instret, 32'd2);

        for (int i = 0; i < 5; i++) begin
            put(5'd3, 2'd1, ld_f3[i], ld_off[i], 32'd0, 32'h8077F0A5, 32'd0);
            cyc();
            chk($sformatf("load%0d_data", i), bus.write_data, ld_exp[i]);
        end

        put(5'd5, 2'd2, 3'd0, 2'd0, 32'h55, 32'd0, 32'h00000104);
        cyc();
        chk("link_data", bus.write_data, 32'h00000104);
        chk("link_addr", 32'(bus.write_port_addr), 32'd5);
        chk("link_instret", bus.instret, 32'd7);

        put(5'd7, 2'd0, 3'd0, 2'd0, 32'h11, 32'd0, 32'd0);
        cyc();
        chk("stall_pre_instret", bus.instret, 32'd8);
        bus.stall      = 1'b1;
        bus.alu_result = 32'h99;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_we", 32'(bus.write_en), 32'd1);
            chk("stall_data", bus.write_data, 32'h11);
            chk("stall_instret", bus.instret, 32'd8);
        end
        bus.flush = 1'b1;
        cyc();
        chk("sf_valid", 32'(bus.wb_valid), 32'd0);
        chk("sf_we", 32'(bus.write_en), 32'd0);
        chk("sf_instret", bus.instret, 32'd9);

        bus.flush = 1'b0;
        bus.stall = 1'b0;
        put(5'd9, 2'd0, 3'd0, 2'd0, 32'h22, 32'd0, 32'd0);
        cyc();
        chk("rm_instret", bus.instret, 32'd9);
        bus.stall = 1'b1;
        cyc();
        chk("rm_we", 32'(bus.write_en), 32'd1);
        rst = 1'b1;
        cyc();
        chk("rm_we0", 32'(bus.write_en), 32'd0);
        chk("rm_addr0", 32'(bus.write_port_addr), 32'd0);
        chk("rm_data0", bus.write_data, 32'd0);
        chk("rm_valid0", 32'(bus.wb_valid), 32'd0);
        chk("rm_instret0", bus.instret, 32'd0);
        rst = 1'b0;
        idle();

        for (int n = 0; n < 3000; n++) begin
            rst                 = ($urandom_range(0, 199) == 0);
            bus.in_valid        = ($urandom_range(0, 3) != 0);
            bus.stall           = ($urandom_range(0, 3) == 0);
            bus.flush           = ($urandom_range(0, 7) == 0);
            bus.reg_write_in    = ($urandom_range(0, 4) != 0);
            bus.rd_addr_in      = 5'($urandom_range(0, 31));
            bus.wb_sel          = 2'($urandom_range(0, 3));
            bus.load_funct3     = 3'($urandom_range(0, 7));
            bus.byte_offset     = 2'($urandom_range(0, 3));
            bus.alu_result      = $urandom;
            bus.mem_rdata       = $urandom;
            bus.pc_plus4        = $urandom;
            bus.read_port_addr1 = ($urandom_range(0, 1) == 1) ? m_rd : 5'($urandom_range(0, 31));
            bus.read_port_addr2 = ($urandom_range(0, 1) == 1) ? m_rd : 5'($urandom_range(0, 31));
            bus.rf_read_data1   = $urandom;
            bus.rf_read_data2   = $urandom;
            cyc();
        end
        rst = 1'b0;
        idle();
        cyc();
        @(negedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the 5-stage pipeline. Holds the MEM/WB pipeline register, selects and extends the writeback value, and drives the register file write port (write_port_addr / write_data / write_en).
- Provides write-through bypass on both register file read ports, so decode sees a value in the same cycle it is being written.
- Maintains a 32-bit retired-instruction counter.

Parameters:
- DATA_W, 32, datapath width.
- ADDR_W, 5, register address width (32 registers; x0 hardwired zero).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  MEM stage presents a valid instruction.
- stall  in  1  hold MEM/WB register contents.
- flush  in  1  load bubble into MEM/WB register.
- reg_write_in  in  1  instruction writes rd.
- rd_addr_in  in  ADDR_W  destination register.
- wb_sel  in  2  00 = ALU, 01 = memory load, 10 = pc+4, 11 = ALU.
- load_funct3  in  3  load type (RV32I encoding).
- byte_offset  in  2  address[1:0] of load.
- alu_result  in  DATA_W  ALU result.
- mem_rdata  in  DATA_W  raw aligned memory word.
- pc_plus4  in  DATA_W  link value.
- read_port_addr1, read_port_addr2  in  ADDR_W  decode read addresses (same nets as register file).
- rf_read_data1, rf_read_data2  in  DATA_W  raw register file outputs.
- write_port_addr  out  ADDR_W  register file write address.
- write_data  out  DATA_W  register file write data.
- write_en  out  1  register file write enable.
- byp_read_data1, byp_read_data2  out  DATA_W  bypassed read data to decode.
- wb_valid  out  1  MEM/WB register holds a valid instruction.
- instret  out  32  retired-instruction count.

Behaviour:
- **MEM/WB register update priority, per edge:**
  - rst: clear the register.
  - else flush: load bubble.
  - else stall: hold.
  - else capture inputs, with valid = in_valid.
- **Captured fields:** valid, reg_write, rd, wb_sel, funct3, byte_offset, alu_result, mem_rdata, pc_plus4.
- **Reset values:**
  - valid = 0; all fields 0; instret = 0.
  - Outputs: write_en = 0, write_port_addr = 0, write_data = 0, wb_valid = 0.
- **Write port (combinational from register contents):**
  - write_en = valid & reg_write & (rd != 0).
  - write_port_addr = rd; write_data = selected value.
- **Latency:** inputs captured at edge N; write presented during cycle N→N+1; register file updates at edge N+1.
- **Stall while valid:** the same write is re-presented every cycle. It is idempotent and allowed.
- **Load extension (wb_sel = 01):**
  - funct3 000 LB: byte at lane byte_offset, sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH: half at lane byte_offset[1], sign-extended.
  - 101 LHU: same half, zero-extended.
  - 010 LW and all other codes: full word.
  - Misaligned halfword (byte_offset[0] = 1) uses byte_offset[1] only; no trap.
- **Bypass:**
  - byp_read_dataK = write_data if write_en and read_port_addrK == write_port_addr; else rf_read_dataK.
  - Address 0 never bypasses; x0 always reads raw (zero).
- **instret:**
  - Increments at an edge where valid = 1 and (stall = 0 or flush = 1), i.e. the entry leaves the stage.
  - A bubble never counts. A write to x0 with reg_write counts.
  - Wraps 0xFFFFFFFF → 0 silently.
- **Simultaneous stall and flush:** flush wins; the held entry retires (counted) and a bubble enters.
- **rst mid-stall:** reset wins; the pending write is dropped and not counted.
- **wb_valid** = valid.

Decomposition:
- Shared pipeline package holds:
  - WB_SEL_ALU/MEM/PC4 constants.
  - Load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - Register address width constant.
- One sub-module: load_extend (combinational; funct3, byte_offset, mem_rdata → extended word). Reused later by a store-to-load forward path.

Test Plan:
- **Write then read:** capture reg_write = 1, rd = 1, wb_sel = 00, alu_result = 0x0C70F26F. Next cycle: write_en = 1, write_port_addr = 1, write_data = 0x0C70F26F. With read_port_addr1 = 1 and rf_read_data1 = 0: byp_read_data1 = 0x0C70F26F. instret increments from 0 to 1.
- **x0 suppression:** rd = 0, reg_write = 1, alu_result = 0xDEADBEEF → write_en = 0. read_port_addr2 = 0 with rf_read_data2 = 0 gives byp_read_data2 = 0. instret still increments.
- **Loads:** mem_rdata = 0x8077F0A5.
  - LB offset 0 → 0xFFFFFFA5.
  - LBU offset 1 → 0x000000F0.
  - LH offset 2 → 0xFFFF8077.
  - LHU offset 0 → 0x0000F0A5.
  - LW → 0x8077F0A5.
- **Link:** wb_sel = 10, pc_plus4 = 0x00000104, rd = 5 → write_data = 0x00000104, write_port_addr = 5.
- **Stall/flush:**
  - Valid entry, stall for 3 cycles: write_en stays 1 and instret unchanged.
  - Then stall = 1 with flush = 1: next cycle wb_valid = 0 and write_en = 0; instret incremented by exactly 1.
- **Reset mid-operation:** valid entry held by stall, assert rst for one edge → write_en = 0, write_port_addr = 0, write_data = 0, wb_valid = 0, instret = 0.
